// File: rtl/mult25x18_share_arbiter.sv
// fifo: generic registered first-word-fallthrough FIFO with occupancy count.
// Latency: a pushed word is visible at the head one clock after the push edge.
// Backpressure: none internally; the writer must never push while full (checked by assertion).
module fifo #(
    parameter int  W     = 8,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat,
    output logic [AW:0]  count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;

    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign pop    = rd_vld && rd_rdy;

    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_vld) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_vld, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (rst)
        !(wr_vld && (count == (AW+1)'(DEPTH))))
        else $error("fifo: write while full");
endmodule

// mult25x18_share_arbiter: round-robin sharing of one pipelined 25x18 multiplier among N_REQ requesters.
// Latency: MULT_LAT+1 edges from operand accept to result at the FIFO head; one accept per clock sustained.
// Backpressure: issue is credit-limited by in-flight products plus FIFO occupancy; RES_READY never reaches REQ_READY combinationally.
// Ports: CLK/RST sync active-high; REQ_VALID/REQ_A/REQ_B/REQ_READY per-requester operand handshake (one-hot grant);
//        MULT_A/MULT_B registered multiplier operands, MULT_P product return; RES_VALID/RES_READY/RES_ID/RES_DATA
//        tagged result stream from the FIFO head; BUSY while anything is in flight or queued.
module mult25x18_share_arbiter #(
    parameter int  N_REQ      = 4,
    parameter int  MULT_LAT   = 4,
    parameter int  FIFO_DEPTH = 8,
    localparam int IDW        = $clog2(N_REQ)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [N_REQ-1:0]    REQ_VALID,
    input  logic [25*N_REQ-1:0] REQ_A,
    input  logic [18*N_REQ-1:0] REQ_B,
    output logic [N_REQ-1:0]    REQ_READY,
    output logic [24:0]         MULT_A,
    output logic [17:0]         MULT_B,
    input  logic [42:0]         MULT_P,
    output logic                RES_VALID,
    input  logic                RES_READY,
    output logic [IDW-1:0]      RES_ID,
    output logic [42:0]         RES_DATA,
    output logic                BUSY
);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + MULT_LAT + 2) + 1;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [42:0]    prod;
    } res_t;

    logic [24:0]       req_a [N_REQ];
    logic [17:0]       req_b [N_REQ];
    logic [IDW-1:0]    last;
    logic [IDW-1:0]    idx;
    logic [IDW-1:0]    winner;
    logic              found;
    logic              can_issue;
    logic              accept;
    // Stage 0 is aligned with the MULT_A/MULT_B register, so the tag in stage
    // MULT_LAT lines up with the cycle in which MULT_P carries its product.
    logic [MULT_LAT:0] tag_vld;
    logic [IDW-1:0]    tag_id [MULT_LAT+1];
    logic [CW-1:0]     inflight;
    logic [FAW:0]      fcount;
    res_t              fifo_wr;
    res_t              fifo_rd;
    logic              fifo_rd_vld;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_a[g] = REQ_A[25*g +: 25];
        assign req_b[g] = REQ_B[18*g +: 18];
    end

    // Search last+1, last+2, ... modulo N_REQ; the first valid requester wins.
    always_comb begin
        idx    = '0;
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IDW'((int'(last) + k) % N_REQ);
            if (!found && REQ_VALID[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Every tagged product is already committed to a FIFO slot, so credit
    // counts the whole tag pipeline plus what is queued, from registered state only.
    always_comb begin
        inflight = '0;
        for (int s = 0; s <= MULT_LAT; s++) begin
            inflight = inflight + CW'(tag_vld[s]);
        end
    end

    assign can_issue = (inflight + CW'(fcount)) < CW'(FIFO_DEPTH);
    assign accept    = found && can_issue && !RST;

    always_comb begin
        REQ_READY = '0;
        if (accept) begin
            REQ_READY[winner] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            MULT_A  <= '0;
            MULT_B  <= '0;
            last    <= IDW'(N_REQ - 1);
            tag_vld <= '0;
            for (int s = 0; s <= MULT_LAT; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            tag_vld   <= {tag_vld[MULT_LAT-1:0], accept};
            tag_id[0] <= winner;
            for (int s = 1; s <= MULT_LAT; s++) begin
                tag_id[s] <= tag_id[s-1];
            end
            if (accept) begin
                MULT_A <= req_a[winner];
                MULT_B <= req_b[winner];
                last   <= winner;
            end
        end
    end

    assign fifo_wr = '{id: tag_id[MULT_LAT], prod: MULT_P};

    fifo #(
        .W     ($bits(res_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk    (CLK),
        .rst    (RST),
        .wr_vld (tag_vld[MULT_LAT]),
        .wr_dat (fifo_wr),
        .rd_vld (fifo_rd_vld),
        .rd_rdy (RES_READY),
        .rd_dat (fifo_rd),
        .count  (fcount)
    );

    // Storage is not reset, so the head is masked to zero while empty.
    assign RES_VALID = fifo_rd_vld;
    assign RES_ID    = fifo_rd_vld ? fifo_rd.id   : '0;
    assign RES_DATA  = fifo_rd_vld ? fifo_rd.prod : '0;
    assign BUSY      = (tag_vld != '0) || (fcount != '0);
endmodule

// File: tb/tb_mult25x18_share_arbiter.sv
// Bench for mult25x18_share_arbiter: directed stimulus with a grant-order queue and result scoreboard.
// Latency: multiplier modelled as MULT_LAT register stages from MULT_A/MULT_B to MULT_P.
// Backpressure: RES_READY driven per scenario to exercise the credit limit.
module tb_mult25x18_share_arbiter;
    localparam int N = 4;
    localparam int L = 4;
    localparam int D = 8;

    typedef struct {
        int          id;
        logic [42:0] data;
        int          acc_edge;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid = '0;
    logic [25*N-1:0] req_a_bus;
    logic [18*N-1:0] req_b_bus;
    logic [N-1:0]   req_ready;
    logic [24:0]    mult_a;
    logic [17:0]    mult_b;
    logic [42:0]    mult_p;
    logic           res_valid;
    logic           res_ready;
    logic [1:0]     res_id;
    logic [42:0]    res_data;
    logic           busy;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_count = 0;
    bit          check_lat = 1'b1;
    logic [24:0] a_op [N];
    logic [17:0] b_op [N];
    logic [42:0] exp_p [N];
    int          remaining [N];
    logic [N-1:0] acc_snap = '0;
    int          grant_q [$];
    exp_t        sb [$];
    exp_t        e;
    int          gid;
    int          eid;
    logic [42:0] p_pipe [L];
    logic [24:0] va [3];
    logic [17:0] vb [3];
    logic [42:0] vp [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_a_bus[25*g +: 25] = a_op[g];
        assign req_b_bus[18*g +: 18] = b_op[g];
    end

    always @(posedge clk) begin
        p_pipe[0] <= 43'(mult_a) * 43'(mult_b);
        for (int k = 1; k < L; k++) p_pipe[k] <= p_pipe[k-1];
    end
    assign mult_p = p_pipe[L-1];

    mult25x18_share_arbiter #(.N_REQ(N), .MULT_LAT(L), .FIFO_DEPTH(D)) dut (
        .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_A(req_a_bus), .REQ_B(req_b_bus),
        .REQ_READY(req_ready), .MULT_A(mult_a), .MULT_B(mult_b), .MULT_P(mult_p),
        .RES_VALID(res_valid), .RES_READY(res_ready), .RES_ID(res_id), .RES_DATA(res_data),
        .BUSY(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Requester model: holds REQ_VALID while it still has requests to send.
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < N; i++) begin
            if (acc_snap[i] && remaining[i] > 0) remaining[i]--;
            req_valid[i] = (remaining[i] > 0);
        end
    end

    // Monitor: checks grants against the expected order and results against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            acc_snap = '0;
        end else begin
            if (res_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stale_result: got id %0d data 0x%0h, expected no result", res_id, res_data);
                end else if (res_ready) begin
                    e = sb.pop_front();
                    chk("res_id", 64'(res_id), 64'(e.id));
                    chk("res_data", 64'(res_data), 64'(e.data));
                    if (check_lat) chk("res_latency", 64'(cyc), 64'(e.acc_edge + L + 1));
                end
            end
            acc_snap = req_valid & req_ready;
            if (acc_snap != '0) begin
                gid = 0;
                for (int i = 0; i < N; i++) if (acc_snap[i]) gid = i;
                chk("grant_onehot", 64'($countones(req_ready)), 64'd1);
                acc_count++;
                if (grant_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got requester %0d, expected no grant", gid);
                    eid = gid;
                end else begin
                    eid = grant_q.pop_front();
                    chk("grant_order", 64'(gid), 64'(eid));
                end
                sb.push_back('{id: eid, data: exp_p[eid], acc_edge: cyc + 1});
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < N; i++) remaining[i] = 0;
        grant_q.delete();
        sb.delete();
        acc_count = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_req_done(input int i, input string name);
        int n = 0;
        do begin
            @(posedge clk); #3;
            n++;
        end while (remaining[i] != 0 && n < 50);
        if (remaining[i] != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d requests outstanding, expected 0", name, remaining[i]);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || grant_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d results pending, expected 0", name, sb.size());
        end
        @(negedge clk);
        chk({name, "_busy_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sum;
        rst = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            a_op[i] = '0; b_op[i] = '0; exp_p[i] = '0;
        end

        // Single requester, held valid through reset.
        a_op[0] = 25'd512; b_op[0] = 18'd512; exp_p[0] = 43'h40000;
        grant_q.push_back(0);
        remaining[0] = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_mult_a", 64'(mult_a), 64'd0);
        chk("rst_mult_b", 64'(mult_b), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_id", 64'(res_id), 64'd0);
        chk("rst_res_data", 64'(res_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_drain("single");

        // Round-robin fairness at full rate.
        do_reset();
        check_lat = 1'b1;
        a_op[0] = 25'd2020; b_op[0] = 18'd2020; exp_p[0] = 43'h3E4310;
        for (int i = 1; i < N; i++) begin
            a_op[i] = 25'd1115; b_op[i] = 18'd1115; exp_p[i] = 43'h12F859;
        end
        for (int r = 0; r < 3; r++) for (int i = 0; i < N; i++) grant_q.push_back(i);
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) remaining[i] = 3;
        repeat (12) @(posedge clk); #3;
        sum = 0;
        for (int i = 0; i < N; i++) sum += remaining[i];
        chk("rr_throughput", 64'(sum), 64'd0);
        wait_drain("rr");

        // Full FIFO: credit stops issue at FIFO_DEPTH, one pop frees one accept.
        do_reset();
        res_ready = 1'b0;
        check_lat = 1'b0;
        for (int r = 0; r < 3; r++) for (int i = 0; i < N; i++) grant_q.push_back(i);
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) remaining[i] = 3;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("full_accepts", 64'(acc_count), 64'(D));
        chk("full_ready_low", 64'(req_ready), 64'd0);
        chk("full_res_valid", 64'(res_valid), 64'd1);
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("full_no_accept_at_pop", 64'(acc_count), 64'(D));
        @(negedge clk);
        chk("full_ready_after_pop", 64'(req_ready), 64'b0001);
        repeat (10) @(negedge clk);
        chk("full_one_more", 64'(acc_count), 64'(D + 1));
        chk("full_ready_low2", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        res_ready = 1'b1;
        wait_drain("full");

        // Pointer wrap: last=2, then requesters 3 and 0 compete.
        do_reset();
        check_lat = 1'b1;
        a_op[2] = 25'd7;   b_op[2] = 18'd9;   exp_p[2] = 43'd63;
        a_op[3] = 25'd100; b_op[3] = 18'd200; exp_p[3] = 43'd20000;
        a_op[0] = 25'd2;   b_op[0] = 18'd3;   exp_p[0] = 43'd6;
        grant_q.push_back(2);
        remaining[2] = 1;
        wait_req_done(2, "wrap_setup");
        grant_q.push_back(3); grant_q.push_back(0);
        grant_q.push_back(3); grant_q.push_back(0);
        remaining[3] = 2;
        remaining[0] = 2;
        wait_drain("wrap");

        // Reset with 3 products in flight and 2 in the FIFO.
        do_reset();
        res_ready = 1'b0;
        check_lat = 1'b0;
        a_op[1] = 25'd11; b_op[1] = 18'd13; exp_p[1] = 43'd143;
        repeat (5) grant_q.push_back(1);
        remaining[1] = 5;
        repeat (7) @(posedge clk); #1;
        chk("mid_accepts", 64'(acc_count), 64'd5);
        chk("mid_res_valid", 64'(res_valid), 64'd1);
        chk("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        for (int i = 0; i < N; i++) remaining[i] = 0;
        grant_q.delete();
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        res_ready = 1'b1;
        check_lat = 1'b1;
        @(negedge clk);
        chk("post_rst_res_valid", 64'(res_valid), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        a_op[3] = 25'd5; b_op[3] = 18'd6;  exp_p[3] = 43'd30;
        a_op[0] = 25'd9; b_op[0] = 18'd10; exp_p[0] = 43'd90;
        grant_q.push_back(0); grant_q.push_back(3);
        @(posedge clk); #1;
        remaining[0] = 1;
        remaining[3] = 1;
        repeat (10) @(negedge clk);
        wait_drain("post_rst");

        // Idle gaps: operands must hold on MULT_A/MULT_B between accepts.
        do_reset();
        check_lat = 1'b1;
        va[0] = 25'd3;    vb[0] = 18'd5;    vp[0] = 43'd15;
        va[1] = 25'd1000; vb[1] = 18'd1000; vp[1] = 43'hF4240;
        va[2] = 25'h1FFFFFF; vb[2] = 18'h3FFFF; vp[2] = 43'h7FFFDFC0001;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            a_op[2] = va[k]; b_op[2] = vb[k]; exp_p[2] = vp[k];
            grant_q.push_back(2);
            remaining[2] = 1;
            wait_req_done(2, "idle_req");
            repeat (2) begin
                @(negedge clk);
                chk("idle_hold_a", 64'(mult_a), 64'(va[k]));
                chk("idle_hold_b", 64'(mult_b), 64'(vb[k]));
            end
        end
        wait_drain("idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
